// File: rtl/ddc_capture.sv
// ddc_capture: AXI-Stream receive capture buffer for the DDC path.
// On ARM it aligns to a tlast frame boundary, stores CAP_LEN {I,Q} beats
// into an internal RAM, pulses cap_done, and serves the captured words,
// a status word and the last command back over the local bus.
module ddc_capture #(
  parameter int          U_DLY     = 1,
  parameter int          FRAME_LEN = 256,
  parameter int          CAP_LEN   = 3840,
  parameter logic [13:0] BASE_ADDR = 14'd0,
  parameter logic [13:0] CMD_ADDR  = 14'd16000,
  parameter logic [13:0] STAT_ADDR = 14'd16001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_tvalid,
  input  logic [31:0] s_tdata,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic        lbs_we,
  input  logic        lbs_re,
  input  logic [13:0] lbs_addr,
  input  logic [31:0] lbs_din,
  output logic [31:0] lbs_dout,
  output logic        lbs_rvalid,
  output logic        cap_done
);

  localparam int AW        = 12;
  localparam int RAM_DEPTH = 1 << AW;
  localparam int WCW       = AW + 1;
  localparam int FCW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FRAME_LEN - 1);
  localparam logic [WCW-1:0] WR_LAST   = WCW'(CAP_LEN - 1);
  localparam logic [13:0]    CAP_LEN_A = 14'(CAP_LEN);
  localparam logic [31:0]    CMD_ARM   = 32'h0000_5555;
  localparam logic [31:0]    CMD_ABORT = 32'h0000_8888;

  // U_DLY only shapes delayed-assignment behavioural models; this RTL
  // uses plain non-blocking assignments, so it has nothing to drive here.
  if (U_DLY < 0) begin : g_udly_unused
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_REG  = 2'd2
  } rd_sel_t;

  // Control state
  logic           ready_q;
  state_t         state_q, state_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           frame_err_q, frame_err_d;
  logic           done_q, done_d;
  logic           cap_done_q, cap_done_d;
  logic [31:0]    cmd_q;
  logic           ram_we;

  // Decoded strobes
  logic beat;
  logic cmd_wr;
  logic arm;
  logic abort;
  logic checking;

  // Read path
  logic [31:0] mem [RAM_DEPTH];
  logic [13:0] rd_off;
  logic        rd_hit_ram;
  rd_sel_t     rd_sel_d, rd_sel_q;
  logic [31:0] rd_aux_d, rd_aux_q;
  logic [31:0] ram_rd_q;
  logic        rd_v1_q;
  logic [31:0] rd_mux;
  logic [31:0] dout_q;
  logic        rvalid_q;
  logic [31:0] status_word;

  assign beat     = s_tvalid & ready_q;
  assign cmd_wr   = lbs_we & (lbs_addr == CMD_ADDR);
  assign arm      = cmd_wr & (lbs_din == CMD_ARM);
  assign abort    = cmd_wr & (lbs_din == CMD_ABORT);
  assign checking = (state_q == ST_ALIGN) | (state_q == ST_CAPTURE);

  // Stream ready is low in reset and high from the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Next-state: frame checker, align/capture sequencing, then commands override.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    fcnt_d      = fcnt_q;
    frame_err_d = frame_err_q;
    done_d      = done_q;
    cap_done_d  = 1'b0;
    ram_we      = 1'b0;

    // Frame length check: a tlast must land exactly on the last beat slot.
    if (checking && beat) begin
      if (s_tlast) begin
        if (fcnt_q != FCNT_LAST) frame_err_d = 1'b1;
        fcnt_d = '0;
      end else if (fcnt_q == FCNT_LAST) begin
        frame_err_d = 1'b1;
        fcnt_d      = '0;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end

    case (state_q)
      ST_ALIGN: begin
        // The tlast beat only marks the boundary; it is not stored.
        if (beat && s_tlast) begin
          state_d = ST_CAPTURE;
          fcnt_d  = '0;
        end
      end
      ST_CAPTURE: begin
        if (beat) begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + WCW'(1);
          if (wr_cnt_q == WR_LAST) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cap_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Commands win over any same-cycle capture progress; the beat itself
    // was already committed to RAM above.
    if (arm) begin
      state_d     = ST_ALIGN;
      done_d      = 1'b0;
      frame_err_d = 1'b0;
      wr_cnt_d    = '0;
      fcnt_d      = '0;
      cap_done_d  = 1'b0;
    end else if (abort) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      fcnt_d     = '0;
      cap_done_d = 1'b0;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      fcnt_q      <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      cap_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      fcnt_q      <= fcnt_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      cap_done_q  <= cap_done_d;
    end
  end

  // Last command word written, readable back at CMD_ADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cmd_q <= '0;
    else if (cmd_wr) cmd_q <= lbs_din;
  end

  assign status_word = {done_q, frame_err_q, (state_q == ST_CAPTURE),
                        (state_q == ST_ALIGN), 16'd0, wr_cnt_q[AW-1:0]};

  assign rd_off     = lbs_addr - BASE_ADDR;
  assign rd_hit_ram = (lbs_addr >= BASE_ADDR) && (rd_off < CAP_LEN_A);

  // Read address decode; register sources take priority over the RAM window.
  always_comb begin
    rd_sel_d = SEL_ZERO;
    rd_aux_d = '0;
    if (lbs_addr == CMD_ADDR) begin
      rd_sel_d = SEL_REG;
      rd_aux_d = cmd_q;
    end else if (lbs_addr == STAT_ADDR) begin
      rd_sel_d = SEL_REG;
      rd_aux_d = status_word;
    end else if (rd_hit_ram) begin
      rd_sel_d = SEL_RAM;
    end
  end

  // Capture RAM: single write port from the stream, registered read port.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_cnt_q[AW-1:0]] <= s_tdata;
    if (lbs_re) ram_rd_q <= mem[rd_off[AW-1:0]];
  end

  // Read stage 1: remember which source answers and snapshot register data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1_q  <= 1'b0;
      rd_sel_q <= SEL_ZERO;
      rd_aux_q <= '0;
    end else begin
      rd_v1_q <= lbs_re;
      if (lbs_re) begin
        rd_sel_q <= rd_sel_d;
        rd_aux_q <= rd_aux_d;
      end
    end
  end

  // Output mux between RAM word, register snapshot and zero.
  always_comb begin
    rd_mux = '0;
    case (rd_sel_q)
      SEL_RAM: rd_mux = ram_rd_q;
      SEL_REG: rd_mux = rd_aux_q;
      default: rd_mux = '0;
    endcase
  end

  // Read stage 2: registered read data with a one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_v1_q;
      if (rd_v1_q) dout_q <= rd_mux;
    end
  end

  assign s_tready   = ready_q;
  assign lbs_dout   = dout_q;
  assign lbs_rvalid = rvalid_q;
  assign cap_done   = cap_done_q;

endmodule

// File: tb/tb_ddc_capture.sv
// tb_ddc_capture: randomized stream/local-bus stimulus with a scoreboard.
// The driver predicts read data and cap_done pulses from a behavioural
// model and queues them; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ddc_capture;

  localparam int          FL    = 256;
  localparam int          CL    = 3840;
  localparam logic [13:0] BASE  = 14'd0;
  localparam logic [13:0] CMDA  = 14'd16000;
  localparam logic [13:0] STATA = 14'd16001;
  localparam logic [31:0] ARM   = 32'h0000_5555;
  localparam logic [31:0] ABORT = 32'h0000_8888;
  localparam int M_IDLE = 0, M_ALIGN = 1, M_CAP = 2, M_DONE = 3;
  localparam int VM_RAND = 0, VM_ON = 1, VM_OFF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        lbs_we = 1'b0;
  logic        lbs_re = 1'b0;
  logic [13:0] lbs_addr = '0;
  logic [31:0] lbs_din = '0;
  logic [31:0] lbs_dout;
  logic        lbs_rvalid;
  logic        cap_done;

  always #5 clk = ~clk;

  ddc_capture #(
    .U_DLY(1), .FRAME_LEN(FL), .CAP_LEN(CL),
    .BASE_ADDR(BASE), .CMD_ADDR(CMDA), .STAT_ADDR(STATA)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .lbs_we(lbs_we), .lbs_re(lbs_re), .lbs_addr(lbs_addr), .lbs_din(lbs_din),
    .lbs_dout(lbs_dout), .lbs_rvalid(lbs_rvalid), .cap_done(cap_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [13:0] addr;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t rq[$];
  int      cq[$];
  rd_exp_t mon_e;
  int      mon_due;

  // Behavioural model of the capture block
  int          m_mode;
  int          m_cnt;
  bit          m_done, m_ferr;
  int          m_inframe;
  logic [31:0] m_cmd;
  bit          m_ready = 1'b0;
  logic [31:0] m_mem[CL];
  bit          m_wr[CL];

  // Stream source
  int          src_pos = 0;
  logic [31:0] src_idx = 0;
  bit          src_gaps = 1'b0;
  bit          src_count = 1'b0;
  bit          inj_tlast = 1'b0;
  bit          rand_rd_en = 1'b1;
  int          src_acc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_clear();
    m_mode = M_IDLE; m_cnt = 0; m_done = 0; m_ferr = 0; m_inframe = 0; m_cmd = '0;
    cq.delete();
  endfunction

  function automatic logic [31:0] model_status();
    logic [11:0] c;
    c = 12'(m_cnt);
    return {m_done, m_ferr, (m_mode == M_CAP), (m_mode == M_ALIGN), 16'd0, c};
  endfunction

  function automatic logic [31:0] model_read(logic [13:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (a == CMDA) return m_cmd;
    if (a == STATA) return model_status();
    if (off >= 0 && off < CL) return m_mem[off];
    return 32'd0;
  endfunction

  // One cycle of the model; beat means the beat was actually accepted.
  function automatic void model_step(bit beat, bit tl, logic [31:0] d, bit cmdwr, logic [31:0] din);
    int old;
    bit fin;
    old = m_mode;
    fin = 0;
    if (beat && (old == M_ALIGN || old == M_CAP)) begin
      m_inframe++;
      if (tl) begin
        if (m_inframe != FL) m_ferr = 1;
        m_inframe = 0;
      end else if (m_inframe == FL) begin
        m_ferr = 1;
        m_inframe = 0;
      end
    end
    if (beat && old == M_ALIGN && tl) begin
      m_mode = M_CAP;
      m_inframe = 0;
    end
    if (beat && old == M_CAP) begin
      m_mem[m_cnt] = d;
      m_wr[m_cnt] = 1;
      m_cnt++;
      if (m_cnt == CL) begin
        m_mode = M_DONE; m_done = 1; fin = 1;
      end
    end
    if (cmdwr) begin
      m_cmd = din;
      if (din == ARM) begin
        m_mode = M_ALIGN; m_done = 0; m_ferr = 0; m_cnt = 0; m_inframe = 0; fin = 0;
      end else if (din == ABORT) begin
        m_mode = M_IDLE; m_done = 0; m_inframe = 0; fin = 0;
      end
    end
    if (fin) cq.push_back(cyc + 1);
  endfunction

  task automatic tick(input bit tv, input bit tl, input logic [31:0] td, input bit we,
                      input bit re, input logic [13:0] addr, input logic [31:0] din,
                      input bit use_exp, input logic [31:0] exp);
    rd_exp_t e;
    s_tvalid = tv; s_tlast = tl; s_tdata = td;
    lbs_we = we; lbs_re = re; lbs_addr = addr; lbs_din = din;
    if (re) begin
      e.due = cyc + 2;
      e.addr = addr;
      e.data = use_exp ? exp : model_read(addr);
      rq.push_back(e);
    end
    model_step(tv && m_ready, tl, td, we && (addr == CMDA), din);
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) m_ready = 1'b1;
  endtask

  task automatic stream(input bit we, input logic [31:0] din, input bit re,
                        input logic [13:0] addr, input bit use_exp,
                        input logic [31:0] exp, input int vmode);
    bit tv, tl, acc;
    logic [31:0] d;
    if (vmode == VM_ON) tv = 1;
    else if (vmode == VM_OFF) tv = 0;
    else tv = !(src_gaps && $urandom_range(7) == 0);
    tl = (src_pos == FL - 1) || inj_tlast;
    d = src_count ? src_idx : $urandom();
    acc = tv && m_ready;
    tick(tv, tl, d, we, re, we ? CMDA : addr, din, use_exp, exp);
    if (acc) begin
      src_acc++;
      src_idx++;
      if (tl) begin
        src_pos = 0;
        inj_tlast = 0;
      end else begin
        src_pos++;
      end
    end
  endtask

  task automatic stream_rand();
    bit re;
    re = rand_rd_en && ($urandom_range(15) == 0);
    stream(0, 0, re, STATA, 0, 0, VM_RAND);
  endtask

  task automatic rd_const(input logic [13:0] a, input logic [31:0] exp);
    stream(0, 0, 1, a, 1, exp, VM_OFF);
  endtask

  task automatic arm_aligned();
    tick(0, 0, 0, 1, 0, CMDA, ARM, 0, 0);
    src_pos = 0;
  endtask

  task automatic run_to_count(input int target, input int budget);
    int n = 0;
    while (!(m_mode == M_CAP && m_cnt == target) && n < budget) begin
      stream_rand();
      n++;
    end
    if (n >= budget) begin
      n_vec++; n_err++;
      $display("FAIL run_to_count: count %0d, required %0d within %0d cycles", m_cnt, target, budget);
    end
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (m_mode != M_DONE && n < budget) begin
      stream_rand();
      n++;
    end
    if (n >= budget) begin
      n_vec++; n_err++;
      $display("FAIL run_to_done: mode %0d, required %0d within %0d cycles", m_mode, M_DONE, budget);
    end
  endtask

  task automatic read_words(input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = $urandom_range(CL - 1);
      if (m_wr[idx]) stream(0, 0, 1, BASE + 14'(idx), 0, 0, VM_RAND);
      else stream(0, 0, 0, STATA, 0, 0, VM_RAND);
    end
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    m_ready = 1'b0;
    model_clear();
    for (int i = 0; i < hold; i++) begin
      s_tvalid = 1'b1; s_tdata = $urandom(); s_tlast = 1'($urandom_range(1));
      lbs_we = 0; lbs_re = 0;
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
  endtask

  // Monitor: reset values, stream ready, read responses and cap_done pulses.
  always @(negedge clk) begin
    check("s_tready", {31'd0, s_tready}, {31'd0, m_ready});
    if (rst) begin
      check("rst_rvalid", {31'd0, lbs_rvalid}, 32'd0);
      check("rst_dout", lbs_dout, 32'd0);
      check("rst_cap_done", {31'd0, cap_done}, 32'd0);
    end else begin
      while (rq.size() > 0 && rq[0].due < cyc) begin
        n_vec++; n_err++;
        $display("FAIL rd_missing: addr %0d got no rvalid, required at cycle %0d", rq[0].addr, rq[0].due);
        void'(rq.pop_front());
      end
      while (cq.size() > 0 && cq[0] < cyc) begin
        n_vec++; n_err++;
        $display("FAIL cap_done_missing: got no pulse, required at cycle %0d", cq[0]);
        void'(cq.pop_front());
      end
      if (lbs_rvalid) begin
        if (rq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rd_spurious: got rvalid with dout 0x%08h, required none", lbs_dout);
        end else begin
          mon_e = rq.pop_front();
          check("rd_latency", cyc, mon_e.due);
          check($sformatf("rd_data@%0d", mon_e.addr), lbs_dout, mon_e.data);
        end
      end
      if (cap_done) begin
        if (cq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL cap_done_spurious: got pulse at cycle %0d, required none", cyc);
        end else begin
          mon_due = cq.pop_front();
          check("cap_done_cycle", cyc, mon_due);
        end
      end
    end
  end

  initial begin
    model_clear();
    #1;
    do_reset(4);

    // 1: frames with no ARM are discarded
    $display("phase 1: idle stream");
    src_gaps = 0; src_count = 0; src_pos = 0;
    rd_const(STATA, 32'h0000_0000);
    for (int i = 0; i < 600; i++) stream_rand();
    rd_const(STATA, 32'h0000_0000);
    rd_const(CMDA, 32'h0000_0000);

    // 2: aligned capture of counting data
    $display("phase 2: full capture");
    src_count = 1; src_idx = 1;
    arm_aligned();
    run_to_done(6000);
    rd_const(STATA, 32'h8000_0F00);
    rd_const(BASE, 32'd257);
    rd_const(CMDA, ARM);
    for (int i = 0; i < CL; i++) stream(0, 0, 1, BASE + 14'(i), 0, 0, VM_RAND);
    rd_const(BASE + 14'(CL), 32'd0);

    // 3: early tlast during capture sets the sticky frame error
    $display("phase 3: frame error");
    src_gaps = 1; src_count = 0;
    arm_aligned();
    begin
      int n = 0;
      while (!(m_mode == M_CAP && m_cnt >= 600 && src_pos == 100) && n < 4000) begin
        stream_rand(); n++;
      end
      if (n >= 4000) begin
        n_vec++; n_err++;
        $display("FAIL inject_wait: got no fcnt 100 slot, required one within 4000 cycles");
      end
    end
    inj_tlast = 1;
    run_to_done(8000);
    rd_const(STATA, 32'hC000_0F00);
    read_words(200);

    // 4: re-ARM mid capture, then ABORT during ALIGN
    $display("phase 4: re-arm and abort");
    arm_aligned();
    run_to_count(1000, 3000);
    arm_aligned();
    src_acc = 0;
    begin
      int n = 0;
      while (src_acc < 50 && n < 200) begin
        stream(0, 0, 0, STATA, 0, 0, VM_RAND); n++;
      end
    end
    stream(1, ABORT, 0, CMDA, 0, 0, VM_OFF);
    rd_const(STATA, 32'h0000_0000);
    for (int i = 0; i < 400; i++) stream_rand();
    rd_const(CMDA, ABORT);

    // 5: ARM collides with the final capture beat
    $display("phase 5: arm on last beat");
    arm_aligned();
    run_to_count(CL - 1, 6000);
    stream(1, ARM, 0, CMDA, 0, 0, VM_ON);
    rd_const(STATA, 32'h1000_0000);
    stream(0, 0, 1, BASE + 14'(CL - 1), 0, 0, VM_OFF);
    for (int i = 0; i < 40; i++) stream_rand();

    // 6: reset in the middle of a capture
    $display("phase 6: reset mid capture");
    src_gaps = 0;
    arm_aligned();
    rand_rd_en = 0;
    run_to_count(2000, 3000);
    for (int i = 0; i < 3; i++) stream(0, 0, 0, STATA, 0, 0, VM_OFF);
    do_reset(3);
    rand_rd_en = 1;
    rd_const(STATA, 32'h0000_0000);
    rd_const(CMDA, 32'h0000_0000);
    for (int i = 0; i < 500; i++) stream_rand();
    rd_const(STATA, 32'h0000_0000);
    read_words(100);

    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 14'd0, 0, 0, 0);
    if (rq.size() != 0 || cq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d reads and %0d pulses pending, required 0", rq.size(), cq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
